phase_acc_nco: RTL and testbench



---
 rtl/phase_acc_nco.sv | 138 +++++++++++++
 tb/tb_phase_acc_nco.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/phase_acc_nco.sv
`default_nettype none
// ============================================================================
// Module   : phase_acc_nco
// Brief    : Phase-accumulator sine NCO with phase offset and a quarter-wave
//            table using quadrant folding. Optional macro PHASE_DITHER_EN adds
//            LFSR dither to the phase before truncation.
// Revision : 1.0 - initial release
// ============================================================================
module phase_acc_nco #(
   parameter int ACC_W    = 24,
   parameter int PHASE_W  = 10,
   parameter int SAMPLE_W = 16,
   parameter     ROM_FILE = "qsin.mem"
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [ACC_W-1:0]           ftw,
   input  logic [PHASE_W-1:0]         phase_off,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       sample_valid,
   output logic                       wrap_sync
);

   localparam int c_mag_w = SAMPLE_W - 1;
   localparam int c_idx_w = PHASE_W - 2;
   localparam int c_depth = 1 << c_idx_w;
   localparam logic [127:0] c_pi_q56 = 128'h3243F6A8885A309;
   localparam logic [127:0] c_amp    = 128'((64'd1 << c_mag_w) - 64'd1);

   // Table entry i = round(amp * sin((i+0.5)*pi/2^(PHASE_W-1))), the same contents
   // ROM_FILE holds, evaluated at elaboration with a Q56 Taylor series.
   function automatic logic [c_mag_w-1:0] qsin_entry(input int idx);
      logic [127:0] x;
      logic [127:0] x2;
      logic [127:0] term;
      logic [127:0] sum;
      x    = (128'(2 * idx + 1) * c_pi_q56) >> PHASE_W;
      x2   = (x * x) >> 56;
      term = x;
      sum  = x;
      for (int k = 1; k <= 12; k++) begin
         term = ((term * x2) >> 56) / 128'((2 * k) * (2 * k + 1));
         if ((k % 2) == 1) sum = sum - term;
         else              sum = sum + term;
      end
      return c_mag_w'(((c_amp * sum) + (128'd1 << 55)) >> 56);
   endfunction

   logic [c_mag_w-1:0] w_rom [0:c_depth-1];

   for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
      localparam logic [c_mag_w-1:0] c_val = qsin_entry(gi);
      assign w_rom[gi] = c_val;
   end

   logic [ACC_W-1:0]   r_acc;
   logic [PHASE_W-1:0] r_off0;
   logic               r_wrap0, r_v0;
   logic [c_idx_w-1:0] r_addr;
   logic               r_neg1, r_wrap1, r_v1;
   logic [c_mag_w-1:0] r_mag;
   logic               r_neg2, r_wrap2, r_v2;

   logic [ACC_W:0]     w_sum;
   logic [ACC_W-1:0]   w_acc_d;
   logic [PHASE_W-1:0] w_p;
   logic [c_idx_w-1:0] w_idx;

   assign w_sum = {1'b0, r_acc} + {1'b0, ftw};

`ifdef PHASE_DITHER_EN
   localparam int c_dith_w = ((ACC_W - PHASE_W) > 16) ? 16 : (ACC_W - PHASE_W);
   logic [15:0] r_lfsr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     r_lfsr <= 16'hACE1;
      else if (en) r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   end

   if (c_dith_w > 0) begin : g_dither
      assign w_acc_d = r_acc + ACC_W'(r_lfsr[c_dith_w-1:0]);
   end else begin : g_no_dither
      assign w_acc_d = r_acc;
   end
`else
   assign w_acc_d = r_acc;
`endif

   assign w_p   = w_acc_d[ACC_W-1 -: PHASE_W] + r_off0;
   assign w_idx = w_p[c_idx_w-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc        <= '0;
         r_off0       <= '0;
         r_wrap0      <= 1'b0;
         r_v0         <= 1'b0;
         r_addr       <= '0;
         r_neg1       <= 1'b0;
         r_wrap1      <= 1'b0;
         r_v1         <= 1'b0;
         r_mag        <= '0;
         r_neg2       <= 1'b0;
         r_wrap2      <= 1'b0;
         r_v2         <= 1'b0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         wrap_sync    <= 1'b0;
      end else begin
         r_v0 <= en;
         if (en) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_wrap0 <= w_sum[ACC_W];
            r_off0  <= phase_off;
         end

         // Odd quadrants walk the quarter table backwards.
         r_addr  <= w_p[PHASE_W-2] ? ~w_idx : w_idx;
         r_neg1  <= w_p[PHASE_W-1];
         r_wrap1 <= r_wrap0;
         r_v1    <= r_v0;

         r_mag   <= w_rom[r_addr];
         r_neg2  <= r_neg1;
         r_wrap2 <= r_wrap1;
         r_v2    <= r_v1;

         sample_valid <= r_v2;
         wrap_sync    <= r_v2 & r_wrap2;
         if (r_v2) begin
            sample_out <= r_neg2 ? -{1'b0, r_mag} : {1'b0, r_mag};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_phase_acc_nco.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_acc_nco
// Brief    : Self-checking bench for phase_acc_nco against an ideal-sine model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_phase_acc_nco;

   localparam int ACC_W    = 24;
   localparam int PHASE_W  = 10;
   localparam int SAMPLE_W = 16;
   localparam real c_pi    = 3.14159265358979323846;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic                       en  = 1'b0;
   logic [ACC_W-1:0]           ftw = '0;
   logic [PHASE_W-1:0]         phase_off = '0;
   logic signed [SAMPLE_W-1:0] sample_out;
   logic                       sample_valid;
   logic                       wrap_sync;

   phase_acc_nco #(
      .ACC_W    (ACC_W),
      .PHASE_W  (PHASE_W),
      .SAMPLE_W (SAMPLE_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .ftw          (ftw),
      .phase_off    (phase_off),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .wrap_sync    (wrap_sync)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int due;
      int smp;
      bit wrap;
   } exp_t;

   exp_t    exp_q[$];
   longint  m_acc     = 0;
   int      last_smp  = 0;
   int      obs_wraps = 0;

   function automatic void check_value(input string tag, input integer got, input integer exp_v);
      checks++;
      if (got !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp_v, cyc);
      end
   endfunction

   // Ideal sine sampled at the centre of the phase bin; real->int rounds half away from zero.
   function automatic int ideal_sample(input int p);
      real amp;
      amp = real'((1 << (SAMPLE_W - 1)) - 1);
      return int'(amp * $sin(2.0 * c_pi * (real'(p) + 0.5) / real'(1 << PHASE_W)));
   endfunction

   // Drive one cycle of inputs; called just after a rising edge.
   task automatic drive(input bit e, input int f, input int o);
      longint sum;
      int     p;
      exp_t   item;
      en        = e;
      ftw       = ACC_W'(f);
      phase_off = PHASE_W'(o);
      if (e) begin
         sum   = m_acc + longint'(ftw);
         m_acc = sum % (64'sd1 << ACC_W);
         p     = int'(((m_acc >> (ACC_W - PHASE_W)) + longint'(phase_off)) % (64'sd1 << PHASE_W));
         item.due  = cyc + 4;
         item.smp  = ideal_sample(p);
         item.wrap = (sum >= (64'sd1 << ACC_W));
         exp_q.push_back(item);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         check_value("valid_hi", sample_valid, 1);
         check_value("sample", $signed(sample_out), e.smp);
         check_value("wrap_sync", wrap_sync, e.wrap ? 1 : 0);
         last_smp = e.smp;
      end else begin
         check_value("valid_lo", sample_valid, 0);
         check_value("wrap_idle", wrap_sync, 0);
         check_value("hold", $signed(sample_out), last_smp);
      end
      if (wrap_sync === 1'b1) obs_wraps++;
   end

   initial begin
      int w0;

      // Reset, then idle with en low.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(10);

      // Static phase: every sample is +ROM[0].
      for (int i = 0; i < 20; i++) drive(1'b1, 0, 0);
      idle(5);
      check_value("ftw0_rom0", $signed(sample_out), 101);

      // Quarter-turn steps: four wraps over sixteen samples, ending on +ROM[0].
      w0 = obs_wraps;
      for (int i = 0; i < 16; i++) drive(1'b1, 24'h400000, 0);
      idle(5);
      check_value("quarter_wraps", obs_wraps - w0, 4);
      check_value("quarter_last", $signed(sample_out), 101);

      // Rotated by a quarter, then frozen.
      for (int i = 0; i < 12; i++) drive(1'b1, 24'h400000, 10'h100);
      for (int i = 0; i < 8; i++)  drive(1'b1, 0, 10'h100);
      idle(5);

      // Reset with three samples in flight.
      for (int i = 0; i < 3; i++) drive(1'b1, 24'h123457, 10'h055);
      en  = 1'b0;
      rst = 1'b1;
      #1;
      check_value("async_sample", $signed(sample_out), 0);
      check_value("async_valid", sample_valid, 0);
      check_value("async_wrap", wrap_sync, 0);
      exp_q.delete();
      m_acc    = 0;
      last_smp = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(6);

      // en every third cycle at 1/16 turn: three wraps over 48 samples from acc=0.
      w0 = obs_wraps;
      for (int i = 0; i < 48; i++) begin
         drive(1'b1, 24'h100000, 0);
         idle(2);
      end
      idle(6);
      check_value("sixteenth_wraps", obs_wraps - w0, 3);

      // Randomised tuning, offset and en pattern.
      for (int i = 0; i < 300; i++) begin
         if ((i % 25) == 0) begin
            ftw       = ACC_W'($urandom);
            phase_off = PHASE_W'($urandom);
         end
         drive($urandom_range(0, 3) != 0, int'(ftw), int'(phase_off));
      end
      idle(6);

      check_value("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
